// File: rtl/md5_hasher_div_seq.sv
// Sequential radix-2 restoring divider: signed dividend / unsigned divisor -> signed quotient and remainder.
// Optional build macro MD5_HASHER_DIV_POW2_EN adds a shift/mask shortcut for power-of-two divisors.
module md5_hasher_div_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      ready,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH:0]    remainder,
  output logic                      div_by_zero
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int DV = DIVISOR_WIDTH;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state, state_next;
  logic [DW-1:0] mag;
  logic [DV:0]   rem;
  logic [DV-1:0] dvs;
  logic          sign;
  logic          dbz;
  logic [CW-1:0] cnt;

  logic [DW-1:0] dividend_mag;
  logic [DV:0]   rem_shift;
  logic [DV:0]   rem_sub;
  logic          ge;
  logic          pow_start;
  logic          pow_pending;

  // -2^(W-1) negates to itself, which is exactly its unsigned magnitude.
  assign dividend_mag = dividend[DW-1] ? -dividend : dividend;
  assign rem_shift    = {rem[DV-1:0], mag[DW-1]};
  assign ge           = rem_shift >= {1'b0, dvs};
  assign rem_sub      = rem_shift - {1'b0, dvs};
  assign ready        = (state == IDLE);

`ifdef MD5_HASHER_DIV_POW2_EN
  localparam int SW = (DV > 1) ? $clog2(DV) : 1;

  logic [SW-1:0] shamt;

  assign pow_start = (divisor != '0) && ((divisor & (divisor - 1'b1)) == '0);

  always_comb begin
    shamt = '0;
    for (int i = 0; i < DV; i++) begin
      if (dvs[i]) shamt = SW'(i);
    end
  end

  // One extra FIX edge turns the latched magnitude into shifted quotient and masked remainder.
  always_ff @(posedge clk) begin
    if (reset) begin
      pow_pending <= 1'b0;
    end else if (ce) begin
      if (state == IDLE && start) pow_pending <= pow_start;
      else if (state == FIX)      pow_pending <= 1'b0;
    end
  end
`else
  assign pow_start   = 1'b0;
  assign pow_pending = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0 || pow_start) state_next = FIX;
          else                            state_next = CALC;
        end
      end
      CALC: if (cnt == CW'(DW - 1)) state_next = FIX;
      FIX:  if (!pow_pending) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mag         <= '0;
      rem         <= '0;
      dvs         <= '0;
      sign        <= 1'b0;
      dbz         <= 1'b0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag  <= dividend_mag;
            rem  <= '0;
            dvs  <= divisor;
            sign <= dividend[DW-1];
            dbz  <= (divisor == '0);
            cnt  <= '0;
          end
        end
        CALC: begin
          mag <= {mag[DW-2:0], ge};
          rem <= ge ? rem_sub : rem_shift;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (pow_pending) begin
`ifdef MD5_HASHER_DIV_POW2_EN
            mag <= mag >> shamt;
            rem <= {1'b0, mag[DV-1:0] & (dvs - 1'b1)};
`endif
          end else begin
            done        <= 1'b1;
            div_by_zero <= dbz;
            if (dbz) begin
              quotient  <= '1;
              remainder <= '0;
            end else begin
              quotient  <= sign ? -mag : mag;
              remainder <= sign ? -rem : rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_hasher_div_seq.sv
// Directed self-checking bench for md5_hasher_div_seq; expectations are hand-computed quotients/remainders.
module tb_md5_hasher_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        done;
  logic [31:0] quotient;
  logic [16:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

`ifdef MD5_HASHER_DIV_POW2_EN
  localparam int POW2_LAT = 2;
`else
  localparam int POW2_LAT = 33;
`endif

  always #5 clk = ~clk;

  md5_hasher_div_seq #(.DIVIDEND_WIDTH(32), .DIVISOR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  // Presents one start pulse; returns at the negedge after the accepting edge.
  task automatic do_start(input logic [31:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen, bounded.
  task automatic wait_done(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 200 && !ok) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; ce = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
    checks++; if (remainder !== 17'h0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    reset = 1'b0;
    ce    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n; bit ok;
    do_start(32'd100, 16'd7);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_busy_ready got %b want 0", ready); end
    wait_done(n, ok);
    checks++; if (!ok || n != 33) begin errors++; $display("FAIL basic_latency got %0d (seen %b) want 33", n, ok); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_quotient got %h want e", quotient); end
    checks++; if (remainder !== 17'd2) begin errors++; $display("FAIL basic_remainder got %h want 2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_done_ready got %b want 1", ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_hold got %h want e", quotient); end
  endtask

  task automatic test_negative;
    int n; bit ok;
    do_start(32'hFFFF_FF9C, 16'd7);
    wait_done(n, ok);
    checks++; if (!ok || n != 33) begin errors++; $display("FAIL neg_latency got %0d (seen %b) want 33", n, ok); end
    checks++; if (quotient !== 32'hFFFF_FFF2) begin errors++; $display("FAIL neg_quotient got %h want fffffff2", quotient); end
    checks++; if (remainder !== 17'h1FFFE) begin errors++; $display("FAIL neg_remainder got %h want 1fffe", remainder); end
  endtask

  task automatic test_back_to_back;
    int n; bit ok;
    do_start(32'h8000_0000, 16'd1);
    wait_done(n, ok);
    checks++; if (!ok || n != POW2_LAT) begin errors++; $display("FAIL minint_latency got %0d (seen %b) want %0d", n, ok, POW2_LAT); end
    checks++; if (quotient !== 32'h8000_0000) begin errors++; $display("FAIL minint_quotient got %h want 80000000", quotient); end
    checks++; if (remainder !== 17'h0) begin errors++; $display("FAIL minint_remainder got %h want 0", remainder); end
    do_start(32'd65535, 16'd65535);
    checks++; if (done !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got done=%b ready=%b want 0 0", done, ready); end
    checks++; if (quotient !== 32'h8000_0000) begin errors++; $display("FAIL b2b_hold got %h want 80000000", quotient); end
    wait_done(n, ok);
    checks++; if (!ok || n != 33) begin errors++; $display("FAIL b2b_latency got %0d (seen %b) want 33", n, ok); end
    checks++; if (quotient !== 32'd1) begin errors++; $display("FAIL b2b_quotient got %h want 1", quotient); end
    checks++; if (remainder !== 17'h0) begin errors++; $display("FAIL b2b_remainder got %h want 0", remainder); end
  endtask

  task automatic test_div_zero;
    int n; bit ok;
    do_start(32'd1234, 16'd0);
    wait_done(n, ok);
    checks++; if (!ok || n != 1) begin errors++; $display("FAIL dbz_latency got %0d (seen %b) want 1", n, ok); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_quotient got %h want ffffffff", quotient); end
    checks++; if (remainder !== 17'h0) begin errors++; $display("FAIL dbz_remainder got %h want 0", remainder); end
  endtask

  task automatic test_stall;
    int done_at = 0;
    int pulses  = 0;
    do_start(32'd1000, 16'd3);
    for (int n = 1; n <= 80; n++) begin
      ce    = (n >= 11 && n <= 15) ? 1'b0 : 1'b1;
      start = (n == 20);
      if (n == 20) begin dividend = 32'd50; divisor = 16'd5; end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        pulses++;
        if (done_at == 0) done_at = n;
      end
    end
    ce = 1'b1; start = 1'b0;
    checks++; if (done_at != 38) begin errors++; $display("FAIL stall_latency got %0d want 38", done_at); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL stall_pulses got %0d want 1", pulses); end
    checks++; if (quotient !== 32'd333) begin errors++; $display("FAIL stall_quotient got %0d want 333", quotient); end
    checks++; if (remainder !== 17'd1) begin errors++; $display("FAIL stall_remainder got %0d want 1", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL stall_dbz got %b want 0", div_by_zero); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL stall_ready got %b want 1", ready); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    do_start(32'd1000, 16'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", ready); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", ready); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL rmid_quotient got %h want 0", quotient); end
    checks++; if (remainder !== 17'h0) begin errors++; $display("FAIL rmid_remainder got %h want 0", remainder); end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", pulses); end
  endtask

  task automatic test_pow2;
    int n; bit ok;
    do_start(32'hFFFF_FFDB, 16'd8);
    wait_done(n, ok);
    checks++; if (!ok || n != POW2_LAT) begin errors++; $display("FAIL pow2_latency got %0d (seen %b) want %0d", n, ok, POW2_LAT); end
    checks++; if (quotient !== 32'hFFFF_FFFC) begin errors++; $display("FAIL pow2_quotient got %h want fffffffc", quotient); end
    checks++; if (remainder !== 17'h1FFFB) begin errors++; $display("FAIL pow2_remainder got %h want 1fffb", remainder); end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_negative();
    test_back_to_back();
    test_div_zero();
    test_stall();
    test_reset_mid();
    test_pow2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
